// File: rtl/subleq_pkg.sv
// Shared definitions for the SUBLEQ sequencer: state encoding, default
// widths, the halt address and the instruction field layout.
package subleq_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;

  // All-ones target address; a taken branch here stops the machine.
  // Held at 32 bits so any address width can take a truncated copy.
  localparam logic [31:0] HALT_ADDR = '1;

  // Instruction word is {A, B, C}; each field is AW bits wide and the
  // constants below give the field index counted from the LSB end.
  localparam int FLD_A = 2;
  localparam int FLD_B = 1;
  localparam int FLD_C = 0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_RDA   = 3'd2,
    S_RDB   = 3'd3,
    S_EXEC  = 3'd4,
    S_HALT  = 3'd5
  } state_t;

  // True while an instruction is in flight.
  function automatic logic is_active(state_t s);
    return (s == S_FETCH) || (s == S_RDA) || (s == S_RDB) || (s == S_EXEC);
  endfunction

endpackage

// File: rtl/subleq_seq_if.sv
// Memory-side bundle of the sequencer: combinational instruction ROM port
// and the synchronous data RAM port.
interface subleq_seq_if
  import subleq_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
);

  logic [AW-1:0]   rom_addr;
  logic [3*AW-1:0] rom_data;
  logic [AW-1:0]   dmem_addr;
  logic [DW-1:0]   dmem_rdata;
  logic [DW-1:0]   dmem_wdata;
  logic            dmem_we;

  // Sequencer side.
  modport master (
    output rom_addr,
    input  rom_data,
    output dmem_addr,
    input  dmem_rdata,
    output dmem_wdata,
    output dmem_we
  );

  // Memory side.
  modport slave (
    input  rom_addr,
    output rom_data,
    input  dmem_addr,
    output dmem_rdata,
    input  dmem_wdata,
    input  dmem_we
  );

endinterface

// File: rtl/subleq_alu.sv
// SUBLEQ datapath: res = B - A (mod 2^DW) and the branch condition
// "result is negative or zero".
module subleq_alu
  import subleq_pkg::*;
#(
  parameter int DW = DW_DEF
) (
  input  logic [DW-1:0] opa,
  input  logic [DW-1:0] opb,
  output logic [DW-1:0] res,
  output logic          leq
);

  // Subtract and flag a non-positive result (sign bit set, or all zero).
  always_comb begin
    res = opb - opa;
    leq = res[DW-1] | ~(|res);
  end

endmodule

// File: rtl/subleq_seq.sv
// Four-cycle multi-cycle SUBLEQ sequencer. Each instruction runs
// FETCH -> RDA -> RDB -> EXEC; a taken branch to the all-ones address
// writes back as usual and then parks the machine in HALT.
module subleq_seq
  import subleq_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         start,
  subleq_seq_if.master bus,
  output logic         busy,
  output logic         halted,
  output logic [15:0]  instr_cnt
);

  localparam logic [AW-1:0] HALT_PC = AW'(HALT_ADDR);
  localparam logic [15:0]   CNT_MAX = 16'hFFFF;

  state_t          state_reg, state_next;
  logic [AW-1:0]   pc_reg,    pc_next;
  logic [3*AW-1:0] ir_reg,    ir_next;
  logic [DW-1:0]   opa_reg,   opa_next;
  logic [15:0]     cnt_reg,   cnt_next;

  logic [AW-1:0]   ir_a, ir_b, ir_c;
  logic [DW-1:0]   alu_res;
  logic            alu_leq;

  assign ir_a = ir_reg[FLD_A*AW +: AW];
  assign ir_b = ir_reg[FLD_B*AW +: AW];
  assign ir_c = ir_reg[FLD_C*AW +: AW];

  // In EXEC the RAM returns mem[B] (address issued in RDB) and opA holds mem[A].
  subleq_alu #(.DW(DW)) u_alu (
    .opa (opa_reg),
    .opb (bus.dmem_rdata),
    .res (alu_res),
    .leq (alu_leq)
  );

  assign bus.rom_addr = pc_reg;
  assign busy         = is_active(state_reg);
  assign halted       = (state_reg == S_HALT);
  assign instr_cnt    = cnt_reg;

  // State and architectural registers; reset aborts whatever is in flight.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= S_IDLE;
      pc_reg    <= '0;
      ir_reg    <= '0;
      opa_reg   <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      ir_reg    <= ir_next;
      opa_reg   <= opa_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic and memory port drive; outputs decode from the state
  // register only, so dmem_we falls with an asynchronous reset.
  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    ir_next        = ir_reg;
    opa_next       = opa_reg;
    cnt_next       = cnt_reg;
    bus.dmem_addr  = '0;
    bus.dmem_wdata = '0;
    bus.dmem_we    = 1'b0;

    unique case (state_reg)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_next    = '0;
          cnt_next   = '0;
          state_next = S_FETCH;
        end
      end

      S_FETCH: begin
        ir_next    = bus.rom_data;
        state_next = S_RDA;
      end

      S_RDA: begin
        bus.dmem_addr = ir_a;
        state_next    = S_RDB;
      end

      S_RDB: begin
        opa_next      = bus.dmem_rdata;
        bus.dmem_addr = ir_b;
        state_next    = S_EXEC;
      end

      S_EXEC: begin
        bus.dmem_addr  = ir_b;
        bus.dmem_wdata = alu_res;
        bus.dmem_we    = 1'b1;
        cnt_next       = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 16'd1;
        if (alu_leq) begin
          pc_next    = ir_c;
          state_next = (ir_c == HALT_PC) ? S_HALT : S_FETCH;
        end else begin
          pc_next    = pc_reg + AW'(1);
          state_next = S_FETCH;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_subleq_seq.sv
// Bench for subleq_seq: instruction-level SUBLEQ interpreter as reference,
// directed scenarios with literal expectations and randomized programs.
module tb_subleq_seq;

  logic        CLK;
  logic        RST_N;
  logic        start;
  logic        busy;
  logic        halted;
  logic [15:0] instr_cnt;

  subleq_seq_if #(.AW(8), .DW(8)) bus ();

  subleq_seq #(.AW(8), .DW(8)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .start     (start),
    .bus       (bus),
    .busy      (busy),
    .halted    (halted),
    .instr_cnt (instr_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memories seen by the DUT.
  logic [23:0] rom     [256];
  logic [7:0]  ram     [256];
  logic [7:0]  ram_img [256];
  logic        load_req;

  assign bus.rom_data = rom[bus.rom_addr];

  // Synchronous RAM with bulk load from the image.
  always @(posedge CLK) begin
    if (load_req) begin
      for (int i = 0; i < 256; i++) ram[i] <= ram_img[i];
    end else if (bus.dmem_we) begin
      ram[bus.dmem_addr] <= bus.dmem_wdata;
    end
    bus.dmem_rdata <= ram[bus.dmem_addr];
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model: architectural state plus position within the
  // four-cycle instruction.
  logic [7:0] mram [256];
  bit         m_run;
  bit         m_halt;
  logic [7:0] m_pc;
  int         m_cnt;
  int         m_phase;

  task automatic checker_loop();
    logic [23:0] ins;
    logic [7:0]  a, b, c, res;
    int          exp_addr;
    bit          exp_we;
    forever begin
      @(negedge CLK);
      if (load_req) for (int i = 0; i < 256; i++) mram[i] = ram_img[i];
      if (!RST_N) begin
        chk("rst_busy",   int'(busy), 0);
        chk("rst_halted", int'(halted), 0);
        chk("rst_rom_addr", int'(bus.rom_addr), 0);
        chk("rst_cnt",    int'(instr_cnt), 0);
        chk("rst_we",     int'(bus.dmem_we), 0);
        m_run = 0; m_halt = 0; m_pc = 8'h00; m_cnt = 0; m_phase = 0;
      end else begin
        ins = rom[m_pc];
        a = ins[23:16]; b = ins[15:8]; c = ins[7:0];
        exp_we   = m_run && (m_phase == 3);
        exp_addr = !m_run ? 0 : (m_phase == 0) ? 0 : (m_phase == 1) ? int'(a) : int'(b);
        chk("busy",      int'(busy), int'(m_run));
        chk("halted",    int'(halted), int'(m_halt));
        chk("rom_addr",  int'(bus.rom_addr), int'(m_pc));
        chk("instr_cnt", int'(instr_cnt), m_cnt);
        chk("dmem_we",   int'(bus.dmem_we), int'(exp_we));
        chk("dmem_addr", int'(bus.dmem_addr), exp_addr);
        if (m_run) begin
          if (m_phase == 3) begin
            res = mram[b] - mram[a];
            chk("dmem_wdata", int'(bus.dmem_wdata), int'(res));
            mram[b] = res;
            m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
            if (res[7] || res == 8'h00) begin
              m_pc = c;
              if (c == 8'hFF) begin m_run = 0; m_halt = 1; end
            end else begin
              m_pc = m_pc + 8'h01;
            end
          end
          m_phase = (m_phase + 1) % 4;
        end else if (start) begin
          m_run = 1; m_halt = 0; m_pc = 8'h00; m_cnt = 0; m_phase = 0;
        end
      end
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    cycles(1);
    start = 1'b0;
  endtask

  task automatic pulse_reset();
    start = 1'b0;
    RST_N = 1'b0;
    cycles(1);
    RST_N = 1'b1;
  endtask

  task automatic load_ram();
    load_req = 1'b1;
    cycles(1);
    load_req = 1'b0;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      rom[i]     = 24'h0000FF;
      ram_img[i] = 8'h00;
    end
  endtask

  initial begin
    RST_N = 1'b0; start = 1'b0; load_req = 1'b0;
    m_run = 0; m_halt = 0; m_pc = 8'h00; m_cnt = 0; m_phase = 0;
    clear_mem();
    for (int i = 0; i < 256; i++) mram[i] = 8'h00;
    fork checker_loop(); join_none

    cycles(1);
    chk("reset_busy",   int'(busy), 0);
    chk("reset_halted", int'(halted), 0);
    chk("reset_pc",     int'(bus.rom_addr), 0);
    RST_N = 1'b1;
    load_ram();
    cycles(3);
    chk("idle_until_start", int'(busy), 0);

    // Basic non-taken subtract.
    clear_mem();
    rom[0] = {8'h01, 8'h02, 8'h05};
    ram_img[1] = 8'd3; ram_img[2] = 8'd5;
    load_ram();
    do_start();
    cycles(3);
    chk("t1_exec_we",    int'(bus.dmem_we), 1);
    chk("t1_exec_wdata", int'(bus.dmem_wdata), 2);
    cycles(1);
    chk("t1_ram2",     int'(ram[2]), 2);
    chk("t1_rom_addr", int'(bus.rom_addr), 1);
    chk("t1_cnt",      int'(instr_cnt), 1);

    // Equal operands: zero result, taken.
    pulse_reset();
    clear_mem();
    rom[0] = {8'h01, 8'h02, 8'h07};
    ram_img[1] = 8'd5; ram_img[2] = 8'd5;
    load_ram();
    do_start();
    cycles(4);
    chk("t2_ram2",     int'(ram[2]), 0);
    chk("t2_rom_addr", int'(bus.rom_addr), 7);

    // Wrap to a positive result: not taken.
    pulse_reset();
    clear_mem();
    rom[0] = {8'h01, 8'h02, 8'h05};
    ram_img[1] = 8'h01; ram_img[2] = 8'h80;
    load_ram();
    do_start();
    cycles(4);
    chk("t3_ram2",     int'(ram[2]), 8'h7F);
    chk("t3_rom_addr", int'(bus.rom_addr), 1);

    // Halt, then restart from HALT.
    pulse_reset();
    clear_mem();
    rom[0] = {8'h03, 8'h03, 8'hFF};
    ram_img[3] = 8'h5A;
    load_ram();
    do_start();
    cycles(4);
    chk("t4_halted",   int'(halted), 1);
    chk("t4_busy",     int'(busy), 0);
    chk("t4_cnt",      int'(instr_cnt), 1);
    chk("t4_ram3",     int'(ram[3]), 0);
    chk("t4_rom_addr", int'(bus.rom_addr), 8'hFF);
    cycles(2);
    chk("t4_stays_halted", int'(halted), 1);
    do_start();
    chk("t4_restart_pc",  int'(bus.rom_addr), 0);
    chk("t4_restart_cnt", int'(instr_cnt), 0);
    chk("t4_restart_busy", int'(busy), 1);

    // PC walks through 0xFF and wraps to 0x00.
    pulse_reset();
    for (int i = 0; i < 256; i++) rom[i] = {8'h10, 8'h11, 8'h00};
    for (int i = 0; i < 256; i++) ram_img[i] = 8'h00;
    ram_img[8'h11] = 8'h01;
    load_ram();
    do_start();
    cycles(1020);
    chk("t5_pc_ff",  int'(bus.rom_addr), 8'hFF);
    cycles(4);
    chk("t5_pc_wrap", int'(bus.rom_addr), 0);
    chk("t5_cnt",     int'(instr_cnt), 256);

    // Reset during EXEC; start while busy is ignored.
    pulse_reset();
    clear_mem();
    rom[0] = {8'h01, 8'h02, 8'h05};
    ram_img[1] = 8'd3; ram_img[2] = 8'd5;
    load_ram();
    do_start();
    start = 1'b1;
    cycles(2);
    start = 1'b0;
    cycles(1);
    chk("t6_in_exec", int'(bus.dmem_we), 1);
    RST_N = 1'b0;
    #1;
    chk("t6_we_async",   int'(bus.dmem_we), 0);
    chk("t6_busy_async", int'(busy), 0);
    chk("t6_pc_async",   int'(bus.rom_addr), 0);
    cycles(1);
    RST_N = 1'b1;
    cycles(2);
    chk("t6_ram_kept", int'(ram[2]), 5);
    chk("t6_idle",     int'(busy), 0);

    // Randomized programs with random start traffic.
    for (int r = 0; r < 6; r++) begin
      pulse_reset();
      for (int i = 0; i < 256; i++) begin
        logic [7:0] a, b, c;
        a = 8'($urandom_range(0, 31));
        b = ($urandom_range(0, 7) == 0) ? a : 8'($urandom_range(0, 31));
        c = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
        rom[i]     = {a, b, c};
        ram_img[i] = 8'($urandom_range(0, 255));
      end
      load_ram();
      do_start();
      for (int k = 0; k < 300; k++) begin
        start = ($urandom_range(0, 9) == 0);
        cycles(1);
      end
      start = 1'b0;
      cycles(1);
      for (int i = 0; i < 32; i++) chk("rand_ram_image", int'(ram[i]), int'(mram[i]));
    end

    pulse_reset();
    cycles(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
